// File: rtl/wb_merge_stage.sv
// Writeback merge: regfilemux for the in-order pipeline plus per-unit long-latency result FIFOs,
// a starvation-aware arbiter and a registered RF write port. Define WB_LOAD_EXT_EN for sel-3 load extraction.

module wb_lu_fifo #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [4:0]  enq_rd,
  input  logic [31:0] enq_data,
  input  logic        deq,
  output logic        nonempty,
  output logic        starved,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data
);
  localparam int PW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CW = $clog2(LU_DEPTH + 1);

  logic [LU_DEPTH-1:0][36:0] mem_q, mem_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [3:0]                age_q, age_d;
  logic                      enq;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(LU_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the current count, so a full FIFO refuses even while draining.
  assign enq_ready = count_q < CW'(LU_DEPTH);
  assign enq       = enq_valid && enq_ready;
  assign nonempty  = count_q != '0;
  assign starved   = nonempty && (age_q >= 4'(STARVE_LIMIT));
  assign {head_rd, head_data} = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) begin
      mem_d[wr_ptr_q] = {enq_rd, enq_data};
      wr_ptr_d        = bump(wr_ptr_q);
    end
    if (deq) rd_ptr_d = bump(rd_ptr_q);
    count_d = count_q + CW'(enq) - CW'(deq);
    if (deq)                                         age_d = '0;
    else if (nonempty && age_q < 4'(STARVE_LIMIT))   age_d = age_q + 4'd1;
    else                                             age_d = age_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

module wb_merge_stage #(
  parameter int NUM_LU       = 2,
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid,
  input  logic [4:0]           pipe_rd,
  input  logic [2:0]           pipe_sel,
  input  logic [2:0]           pipe_funct3,
  input  logic [1:0]           pipe_addr_lo,
  input  logic [31:0]          pipe_alu_out,
  input  logic [31:0]          pipe_u_imm,
  input  logic [31:0]          pipe_rdata,
  input  logic [31:0]          pipe_pc,
  input  logic                 pipe_br_en,
  output logic                 pipe_stall,
  input  logic [NUM_LU-1:0]    lu_valid,
  output logic [NUM_LU-1:0]    lu_ready,
  input  logic [5*NUM_LU-1:0]  lu_rd,
  input  logic [32*NUM_LU-1:0] lu_data,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [31:0]          rf_wdata
);
  localparam int RW = (NUM_LU > 1) ? $clog2(NUM_LU) : 1;

  logic [NUM_LU-1:0]        fifo_ready, nonempty, starved, gnt_lu;
  logic [NUM_LU-1:0][4:0]   head_rd;
  logic [NUM_LU-1:0][31:0]  head_data;
  logic                     gnt_pipe, gnt_any;
  logic [RW-1:0]            gnt_idx;
  logic [RW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [31:0]              ld_data, pipe_wdata, sel_data;
  logic [4:0]               sel_rd;
  logic                     rf_we_q, rf_we_d;
  logic [4:0]               rf_rd_q, rf_rd_d;
  logic [31:0]              rf_wdata_q, rf_wdata_d;

  for (genvar i = 0; i < NUM_LU; i++) begin : g_lu
    wb_lu_fifo #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .enq_valid (lu_valid[i]),
      .enq_ready (fifo_ready[i]),
      .enq_rd    (lu_rd[5*i +: 5]),
      .enq_data  (lu_data[32*i +: 32]),
      .deq       (gnt_lu[i]),
      .nonempty  (nonempty[i]),
      .starved   (starved[i]),
      .head_rd   (head_rd[i]),
      .head_data (head_data[i])
    );
  end

  assign lu_ready = fifo_ready | {NUM_LU{~rst}};

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    case (pipe_addr_lo)
      2'd0:    ld_byte = pipe_rdata[7:0];
      2'd1:    ld_byte = pipe_rdata[15:8];
      2'd2:    ld_byte = pipe_rdata[23:16];
      default: ld_byte = pipe_rdata[31:24];
    endcase
    ld_half = pipe_addr_lo[1] ? pipe_rdata[31:16] : pipe_rdata[15:0];
    case (pipe_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = pipe_rdata;
    endcase
  end
`else
  logic unused_ld;
  assign unused_ld = ^{pipe_funct3, pipe_addr_lo};
  assign ld_data   = pipe_rdata;
`endif

  always_comb begin
    case (pipe_sel)
      3'd0:    pipe_wdata = pipe_alu_out;
      3'd1:    pipe_wdata = {31'd0, pipe_br_en};
      3'd2:    pipe_wdata = pipe_u_imm;
      3'd3:    pipe_wdata = ld_data;
      3'd4:    pipe_wdata = pipe_pc + 32'd4;
      default: pipe_wdata = 32'd0;
    endcase
  end

  // Descending loops let the lowest qualifying index win; the last rr loop overrides
  // the wrap-around pick whenever some unit at or after rr_ptr is waiting.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    gnt_pipe = 1'b0;
    for (int i = NUM_LU - 1; i >= 0; i--)
      if (starved[i]) begin gnt_idx = RW'(i); gnt_any = 1'b1; end
    if (!gnt_any && pipe_valid) begin gnt_pipe = 1'b1; gnt_any = 1'b1; end
    if (!gnt_any) begin
      for (int i = NUM_LU - 1; i >= 0; i--)
        if (nonempty[i]) begin gnt_idx = RW'(i); gnt_any = 1'b1; end
      for (int i = NUM_LU - 1; i >= 0; i--)
        if (nonempty[i] && RW'(i) >= rr_ptr_q) begin gnt_idx = RW'(i); gnt_any = 1'b1; end
    end
    for (int i = 0; i < NUM_LU; i++)
      gnt_lu[i] = gnt_any && !gnt_pipe && (gnt_idx == RW'(i));
  end

  assign pipe_stall = pipe_valid && (!rst || !gnt_pipe);

  always_comb begin
    sel_rd   = pipe_rd;
    sel_data = pipe_wdata;
    for (int i = 0; i < NUM_LU; i++)
      if (gnt_lu[i]) begin sel_rd = head_rd[i]; sel_data = head_data[i]; end
    rf_we_d    = gnt_any && (sel_rd != 5'd0);
    rf_rd_d    = gnt_any ? sel_rd   : rf_rd_q;
    rf_wdata_d = gnt_any ? sel_data : rf_wdata_q;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_any && !gnt_pipe)
      rr_ptr_d = (gnt_idx == RW'(NUM_LU - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_merge_stage.sv
// Scoreboard bench for wb_merge_stage: stimulus pushes expected RF writes, a negedge monitor pops them.

module tb_wb_merge_stage;
  localparam int NUM_LU = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 pipe_valid, pipe_br_en, pipe_stall;
  logic [4:0]           pipe_rd;
  logic [2:0]           pipe_sel, pipe_funct3;
  logic [1:0]           pipe_addr_lo;
  logic [31:0]          pipe_alu_out, pipe_u_imm, pipe_rdata, pipe_pc;
  logic [NUM_LU-1:0]    lu_valid, lu_ready;
  logic [5*NUM_LU-1:0]  lu_rd;
  logic [32*NUM_LU-1:0] lu_data;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [31:0]          rf_wdata;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

`ifdef WB_LOAD_EXT_EN
  localparam logic [31:0] EXP_LB  = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_LHU = 32'h0000_80FF;
`else
  localparam logic [31:0] EXP_LB  = 32'h80FF_7F01;
  localparam logic [31:0] EXP_LHU = 32'h80FF_7F01;
`endif

  always #5 clk = ~clk;

  wb_merge_stage #(.NUM_LU(NUM_LU), .LU_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_sel(pipe_sel),
    .pipe_funct3(pipe_funct3), .pipe_addr_lo(pipe_addr_lo),
    .pipe_alu_out(pipe_alu_out), .pipe_u_imm(pipe_u_imm), .pipe_rdata(pipe_rdata),
    .pipe_pc(pipe_pc), .pipe_br_en(pipe_br_en), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  // One accepted pipeline result: drive, record the expected write, confirm no stall.
  task automatic drive(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] exp);
    pipe_valid = 1'b1; pipe_sel = sel; pipe_rd = rd; pipe_alu_out = alu;
    pipe_funct3 = f3; pipe_addr_lo = alo;
    push(rd, exp);
    #1;
    chk($sformatf("stall_sel%0d_rd%0d", sel, rd), 32'(pipe_stall), 32'd0);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write", rf_rd, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_rd !== mon_e.rd || rf_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=0x%08h, expected rd=%0d data=0x%08h",
                   rf_rd, rf_wdata, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    int na, nb;
    logic [1:0] rdy_exp [5];
    rdy_exp = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01};

    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_sel = 3'd0; pipe_funct3 = 3'd0; pipe_addr_lo = 2'd0;
    pipe_alu_out = 32'h0000_AAAA; pipe_u_imm = 32'h1234_5000; pipe_rdata = 32'h80FF_7F01;
    pipe_pc = 32'hFFFF_FFFC; pipe_br_en = 1'b1;
    lu_valid = '0; lu_rd = '0; lu_data = '0;

    // Reset held two cycles with a valid pipeline instruction.
    tick();
    chk("reset_rf_we",    32'(rf_we), 32'd0);
    chk("reset_rf_rd",    32'(rf_rd), 32'd0);
    chk("reset_rf_wdata", rf_wdata,   32'd0);
    chk("reset_lu_ready", 32'(lu_ready), 32'h3);
    chk("reset_stall",    32'(pipe_stall), 32'd1);
    tick();
    rst = 1'b1;
    push(5'd3, 32'h0000_AAAA);
    #1;
    chk("release_stall", 32'(pipe_stall), 32'd0);
    tick();

    // Regfilemux selects.
    drive(3'd4, 5'd5,  32'd0, 3'd0, 2'd0, 32'h0000_0000);
    drive(3'd1, 5'd6,  32'd0, 3'd0, 2'd0, 32'h0000_0001);
    drive(3'd2, 5'd8,  32'd0, 3'd0, 2'd0, 32'h1234_5000);
    drive(3'd3, 5'd9,  32'd0, 3'd0, 2'd2, EXP_LB);
    drive(3'd3, 5'd12, 32'd0, 3'd5, 2'd2, EXP_LHU);
    drive(3'd3, 5'd13, 32'd0, 3'd2, 2'd0, 32'h80FF_7F01);
    drive(3'd6, 5'd11, 32'd0, 3'd0, 2'd0, 32'h0000_0000);
    drive(3'd0, 5'd10, 32'h0000_5555, 3'd0, 2'd0, 32'h0000_5555);
    pipe_valid = 1'b0;
    tick();
    chk("idle_rf_we",    32'(rf_we), 32'd0);
    chk("idle_rf_rd",    32'(rf_rd), 32'd10);
    chk("idle_rf_wdata", rf_wdata,   32'h0000_5555);

    // x0 result from LU0: consumed, never written.
    lu_valid = 2'b01; lu_rd = {5'd0, 5'd0}; lu_data = {32'd0, 32'h0000_1234};
    tick();
    lu_valid = '0;
    tick();
    chk("x0_rf_we",    32'(rf_we), 32'd0);
    chk("x0_rf_rd",    32'(rf_rd), 32'd0);
    chk("x0_rf_wdata", rf_wdata,   32'h0000_1234);
    tick();
    chk("x0_lu_ready", 32'(lu_ready), 32'h3);
    chk("x0_drained_we", 32'(rf_we), 32'd0);

    // Starvation: LU1 entry waits behind a streaming pipeline.
    pipe_valid = 1'b1; pipe_sel = 3'd0; pipe_rd = 5'd1; pipe_alu_out = 32'h100;
    lu_valid = 2'b10; lu_rd = {5'd7, 5'd0}; lu_data = {32'h0000_7777, 32'd0};
    push(5'd1, 32'h100);
    #1;
    chk("starve_c0_stall", 32'(pipe_stall), 32'd0);
    tick();
    lu_valid = '0;
    for (int c = 1; c <= 5; c++) begin
      pipe_alu_out = 32'h100 + 32'(c);
      if (c < 5) push(5'd1, pipe_alu_out);
      else       push(5'd7, 32'h0000_7777);
      #1;
      chk($sformatf("starve_c%0d_stall", c), 32'(pipe_stall), (c == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("starve_rf_rd", 32'(rf_rd), 32'd7);
    push(5'd1, 32'h105);
    #1;
    chk("starve_c6_stall", 32'(pipe_stall), 32'd0);
    tick();
    pipe_valid = 1'b0;

    // Round-robin with backpressure: three results per unit, no pipeline traffic.
    push(5'd11, 32'hA0); push(5'd21, 32'hB0);
    push(5'd12, 32'hA1); push(5'd22, 32'hB1);
    push(5'd13, 32'hA2); push(5'd23, 32'hB2);
    na = 0; nb = 0;
    for (int c = 0; c < 8; c++) begin
      lu_valid = {nb < 3, na < 3};
      lu_rd    = {5'(21 + nb), 5'(11 + na)};
      lu_data  = {32'(32'hB0 + nb), 32'(32'hA0 + na)};
      #1;
      if (c < 5) chk($sformatf("rr_ready_c%0d", c), 32'(lu_ready), 32'(rdy_exp[c]));
      if (lu_valid[0] && lu_ready[0]) na++;
      if (lu_valid[1] && lu_ready[1]) nb++;
      tick();
    end
    lu_valid = '0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("rr_drain", 32'(exp_q.size()), 32'd0);

    // Reset with a buffered LU result discards it.
    lu_valid = 2'b01; lu_rd = {5'd0, 5'd15}; lu_data = {32'd0, 32'h0000_DEAD};
    tick();
    lu_valid = '0;
    rst = 1'b0;
    #1;
    chk("midrst_lu_ready", 32'(lu_ready), 32'h3);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_rf_rd", 32'(rf_rd), 32'd0);
    tick();
    chk("midrst_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("midrst_rf_we2", 32'(rf_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
